kairo_reg_dbgctl: RTL and testbench

//  Debug-side controller for the kairo register file access port (AR_*). Accepts

---
 rtl/kairo_reg_dbgctl.sv | 202 ++++++++++++++++++++
 tb/tb_kairo_reg_dbgctl.sv | 214 +++++++++++++++++++++
 2 files changed

// File: rtl/kairo_reg_dbgctl.sv
// kairo_reg_dbgctl: debug-side controller for the kairo register file access port.
// Takes one read/write request at a time from the debug bus, halts the core,
// runs the AR_* access sequence (1-cycle registered read latency), returns data
// with a one-cycle ACK, then releases the halt.
//
// Configuration macro: KAIRO_DBG_STICKY_HALT_EN
//   defined   : core halt is kept after DONE until dbg_resume is seen in IDLE
//   undefined : halt released in DONE, dbg_resume ignored
//
// Ports:
//   clk, rst_n      clock, async active-low reset
//   dbg_req         request level, held until dbg_ack
//   dbg_wr          1 = write, 0 = read (valid with dbg_req)
//   dbg_addr        register index
//   dbg_wdata       write data
//   dbg_resume      release sticky halt
//   dbg_ack         one-cycle completion pulse
//   dbg_err         valid with dbg_ack: halt timeout, no access performed
//   dbg_rdata       read data, held until the next ack
//   core_halt_req   ask the core to drain and stop issuing writes
//   core_halted     core drained, no register write in flight
//   ar_en, ar_wr    access port enable / write
//   ar_ad, ar_di    access address / write data
//   ar_do           access read data (valid one cycle after ar_en)
module kairo_reg_dbgctl #(
   parameter int unsigned HALT_TIMEOUT = 255
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        dbg_req,
   input  logic        dbg_wr,
   input  logic [4:0]  dbg_addr,
   input  logic [31:0] dbg_wdata,
   input  logic        dbg_resume,
   output logic        dbg_ack,
   output logic        dbg_err,
   output logic [31:0] dbg_rdata,
   output logic        core_halt_req,
   input  logic        core_halted,
   output logic        ar_en,
   output logic        ar_wr,
   output logic [4:0]  ar_ad,
   output logic [31:0] ar_di,
   input  logic [31:0] ar_do
);

   localparam int unsigned AW = 5;
   localparam int unsigned DW = 32;
   localparam int unsigned CW = (HALT_TIMEOUT > 0) ? $clog2(HALT_TIMEOUT + 1) : 1;

`ifdef KAIRO_DBG_STICKY_HALT_EN
   localparam bit STICKY = 1'b1;
`else
   localparam bit STICKY = 1'b0;
`endif

   typedef enum logic [2:0] {
      S_IDLE   = 3'd0,
      S_HALT   = 3'd1,
      S_ACCESS = 3'd2,
      S_RDWAIT = 3'd3,
      S_DONE   = 3'd4
   } state_t;

   state_t          state_q, state_d;
   logic [CW-1:0]   cnt_q, cnt_d, cnt_inc;
   logic            wr_q, wr_d;
   logic [AW-1:0]   addr_q, addr_d;
   logic [DW-1:0]   wdata_q, wdata_d;
   logic            hold_q, hold_d;

   logic            ack_d, err_d, halt_req_d, en_d, arwr_d;
   logic [AW-1:0]   ad_d;
   logic [DW-1:0]   di_d, rdata_d;
   logic            addr_nz_c;

   // Register 0 is never touched on the access port.
   assign addr_nz_c = |addr_q;

   // State, latched request, and registered outputs.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q       <= S_IDLE;
         cnt_q         <= '0;
         wr_q          <= 1'b0;
         addr_q        <= '0;
         wdata_q       <= '0;
         hold_q        <= 1'b0;
         dbg_ack       <= 1'b0;
         dbg_err       <= 1'b0;
         dbg_rdata     <= '0;
         core_halt_req <= 1'b0;
         ar_en         <= 1'b0;
         ar_wr         <= 1'b0;
         ar_ad         <= '0;
         ar_di         <= '0;
      end else begin
         state_q       <= state_d;
         cnt_q         <= cnt_d;
         wr_q          <= wr_d;
         addr_q        <= addr_d;
         wdata_q       <= wdata_d;
         hold_q        <= hold_d;
         dbg_ack       <= ack_d;
         dbg_err       <= err_d;
         dbg_rdata     <= rdata_d;
         core_halt_req <= halt_req_d;
         ar_en         <= en_d;
         ar_wr         <= arwr_d;
         ar_ad         <= ad_d;
         ar_di         <= di_d;
      end
   end

   // Next state; output values are those of the state being entered.
   always_comb begin
      state_d    = state_q;
      cnt_d      = cnt_q;
      wr_d       = wr_q;
      addr_d     = addr_q;
      wdata_d    = wdata_q;
      hold_d     = hold_q;
      ack_d      = 1'b0;
      err_d      = 1'b0;
      halt_req_d = hold_q;
      en_d       = 1'b0;
      arwr_d     = 1'b0;
      ad_d       = '0;
      di_d       = '0;
      rdata_d    = dbg_rdata;
      cnt_inc    = cnt_q + CW'(1);

      case (state_q)
         S_IDLE: begin
            if (dbg_req) begin
               wr_d       = dbg_wr;
               addr_d     = dbg_addr;
               wdata_d    = dbg_wdata;
               cnt_d      = '0;
               halt_req_d = 1'b1;
               state_d    = S_HALT;
            end else if (STICKY && dbg_resume) begin
               hold_d     = 1'b0;
               halt_req_d = 1'b0;
            end
         end

         S_HALT: begin
            halt_req_d = 1'b1;
            cnt_d      = cnt_inc;
            if (core_halted) begin
               state_d = S_ACCESS;
               cnt_d   = '0;
               en_d    = addr_nz_c;
               arwr_d  = addr_nz_c && wr_q;
               ad_d    = addr_nz_c ? addr_q : '0;
               di_d    = (addr_nz_c && wr_q) ? wdata_q : '0;
            end else if ((HALT_TIMEOUT != 0) && (cnt_inc == CW'(HALT_TIMEOUT))) begin
               // Core never drained: give up without touching the register file.
               state_d    = S_DONE;
               cnt_d      = '0;
               ack_d      = 1'b1;
               err_d      = 1'b1;
               hold_d     = 1'b0;
               halt_req_d = 1'b0;
            end
         end

         S_ACCESS: begin
            if (wr_q) begin
               state_d    = S_DONE;
               ack_d      = 1'b1;
               hold_d     = STICKY;
               halt_req_d = STICKY;
            end else begin
               // Keep the read address up while the registered read returns.
               state_d    = S_RDWAIT;
               halt_req_d = 1'b1;
               en_d       = addr_nz_c;
               ad_d       = addr_nz_c ? addr_q : '0;
            end
         end

         S_RDWAIT: begin
            state_d    = S_DONE;
            ack_d      = 1'b1;
            rdata_d    = addr_nz_c ? ar_do : '0;
            hold_d     = STICKY;
            halt_req_d = STICKY;
         end

         S_DONE: begin
            state_d = S_IDLE;
         end

         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

endmodule

// File: tb/tb_kairo_reg_dbgctl.sv
// tb_kairo_reg_dbgctl: directed + randomized bench for kairo_reg_dbgctl.
// A behavioural register-file array answers the access port; a separate
// reference memory and per-transaction latency/enable counts predict results.
module tb_kairo_reg_dbgctl;

   localparam int unsigned TMO   = 8;
   localparam int          NEVER = 255;

`ifdef KAIRO_DBG_STICKY_HALT_EN
   localparam bit STICKY = 1'b1;
`else
   localparam bit STICKY = 1'b0;
`endif

   logic        clk = 1'b0;
   logic        rst_n;
   logic        dbg_req, dbg_wr, dbg_resume;
   logic [4:0]  dbg_addr;
   logic [31:0] dbg_wdata;
   logic        dbg_ack, dbg_err;
   logic [31:0] dbg_rdata;
   logic        core_halt_req, core_halted;
   logic        ar_en, ar_wr;
   logic [4:0]  ar_ad;
   logic [31:0] ar_di;
   logic [31:0] ar_do = 32'h0;

   logic [31:0] rf      [32];
   logic [31:0] ref_mem [32];
   logic [31:0] last_rd;
   int          n_vec = 0;
   int          n_err = 0;

   always #5 clk = ~clk;

   kairo_reg_dbgctl #(.HALT_TIMEOUT(TMO)) dut (
      .clk           (clk),
      .rst_n         (rst_n),
      .dbg_req       (dbg_req),
      .dbg_wr        (dbg_wr),
      .dbg_addr      (dbg_addr),
      .dbg_wdata     (dbg_wdata),
      .dbg_resume    (dbg_resume),
      .dbg_ack       (dbg_ack),
      .dbg_err       (dbg_err),
      .dbg_rdata     (dbg_rdata),
      .core_halt_req (core_halt_req),
      .core_halted   (core_halted),
      .ar_en         (ar_en),
      .ar_wr         (ar_wr),
      .ar_ad         (ar_ad),
      .ar_di         (ar_di),
      .ar_do         (ar_do)
   );

   // Register file with a one-cycle registered read.
   always @(posedge clk) begin
      if (ar_en && ar_wr) rf[ar_ad] <= ar_di;
      if (ar_en) ar_do <= rf[ar_ad];
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_vec++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
      end
   endtask

   task automatic chk_all_zero(input string tag);
      chk({tag, "_ctl"}, 32'({dbg_ack, dbg_err, core_halt_req, ar_en, ar_wr}), 32'h0);
      chk({tag, "_ad"}, 32'(ar_ad), 32'h0);
      chk({tag, "_di"}, ar_di, 32'h0);
      chk({tag, "_rdata"}, dbg_rdata, 32'h0);
   endtask

   // One request; dly = cycle in which core_halted rises (0 = already high, NEVER = never).
   task automatic txn(input logic wr, input logic [4:0] a, input logic [31:0] d, input int dly);
      int          cyc, en_n, wr_n, ad_bad, di_bad, hr_bad, exp_lat, exp_en, exp_wr;
      logic        got, exp_err;
      logic [31:0] exp_rd;
      cyc = 0; en_n = 0; wr_n = 0; ad_bad = 0; di_bad = 0; hr_bad = 0; got = 1'b0;
      exp_err = (dly == NEVER);
      exp_lat = exp_err ? int'(TMO) + 1 : ((dly == 0) ? 0 : dly - 1) + (wr ? 3 : 4);
      exp_en  = (exp_err || a == 5'd0) ? 0 : (wr ? 1 : 2);
      exp_wr  = (!exp_err && a != 5'd0 && wr) ? 1 : 0;
      if (exp_err || wr) exp_rd = last_rd;
      else               exp_rd = (a == 5'd0) ? 32'h0 : ref_mem[a];

      chk("rdata_hold", dbg_rdata, last_rd);
      core_halted = (dly == 0);
      dbg_req = 1'b1; dbg_wr = wr; dbg_addr = a; dbg_wdata = d;
      @(posedge clk);
      while (!got && cyc < 40) begin
         @(negedge clk);
         cyc++;
         if (cyc == 1) begin
            // Request fields must be ignored once latched.
            dbg_wr = 1'($urandom); dbg_addr = 5'($urandom); dbg_wdata = $urandom;
         end
         if (ar_en) begin
            en_n++;
            if (ar_ad !== a) ad_bad++;
         end
         if (ar_wr) begin
            wr_n++;
            if (!ar_en || ar_di !== d) di_bad++;
         end
         if (dbg_ack) begin
            got = 1'b1;
            chk("ack_err", 32'(dbg_err), 32'(exp_err));
            chk("ack_rdata", dbg_rdata, exp_rd);
            chk("ack_halt_req", 32'(core_halt_req), 32'(STICKY && !exp_err));
            dbg_req = 1'b0;
         end else if (core_halt_req !== 1'b1) begin
            hr_bad++;
         end
         if (dly != NEVER && cyc == dly) core_halted = 1'b1;
      end
      dbg_req = 1'b0;
      chk("latency", 32'(cyc), 32'(exp_lat));
      chk("ar_en_cycles", 32'(en_n), 32'(exp_en));
      chk("ar_wr_cycles", 32'(wr_n), 32'(exp_wr));
      chk("ar_ad_wrong", 32'(ad_bad), 32'h0);
      chk("ar_di_wrong", 32'(di_bad), 32'h0);
      chk("halt_req_drop", 32'(hr_bad), 32'h0);
      if (!exp_err && wr && a != 5'd0) ref_mem[a] = d;
      last_rd = exp_rd;
      @(negedge clk);
      chk("ack_pulse", 32'({dbg_ack, ar_en}), 32'h0);
   endtask

   initial begin
      for (int i = 0; i < 32; i++) begin
         rf[i] = 32'h0;
         ref_mem[i] = 32'h0;
      end
      last_rd = 32'h0;
      rst_n = 1'b0; dbg_req = 1'b0; dbg_wr = 1'b0; dbg_addr = 5'd0;
      dbg_wdata = 32'h0; dbg_resume = 1'b0; core_halted = 1'b0;
      repeat (3) @(negedge clk);
      chk_all_zero("reset");
      rst_n = 1'b1;
      @(negedge clk);

      // Directed: write/read addr 5, addr 0 accesses, halt timeout.
      txn(1'b1, 5'd5, 32'hDEADBEEF, 0);
      txn(1'b0, 5'd5, 32'h0, 0);
      txn(1'b1, 5'd0, 32'h12345678, 0);
      txn(1'b0, 5'd0, 32'h0, 0);
      txn(1'b0, 5'd5, 32'h0, 3);
      txn(1'b0, 5'd5, 32'h0, NEVER);
      txn(1'b1, 5'd6, 32'hCAFEF00D, NEVER);

      // Reset while the read data is in flight.
      core_halted = 1'b1;
      dbg_req = 1'b1; dbg_wr = 1'b0; dbg_addr = 5'd5;
      @(posedge clk);
      repeat (3) @(negedge clk);
      chk("rdwait_en", 32'({ar_en, ar_wr}), 32'h2);
      rst_n = 1'b0;
      dbg_req = 1'b0;
      #1;
      chk_all_zero("rst_rdwait");
      last_rd = 32'h0;
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      txn(1'b0, 5'd5, 32'h0, 0);

      // Randomized traffic over a small address window.
      for (int n = 0; n < 40; n++) begin
         logic        w;
         logic [4:0]  a;
         int          dl;
         w  = 1'($urandom_range(0, 1));
         a  = 5'($urandom_range(0, 7));
         dl = ($urandom_range(0, 3) == 0) ? int'($urandom_range(2, 6)) : 0;
         txn(w, a, $urandom, dl);
      end

`ifdef KAIRO_DBG_STICKY_HALT_EN
      txn(1'b0, 5'd5, 32'h0, 0);
      txn(1'b0, 5'd6, 32'h0, 0);
      repeat (3) begin
         @(negedge clk);
         chk("sticky_hold", 32'(core_halt_req), 32'h1);
      end
      dbg_resume = 1'b1;
      @(negedge clk);
      dbg_resume = 1'b0;
      chk("sticky_release", 32'(core_halt_req), 32'h0);
      @(negedge clk);
      chk("sticky_released", 32'(core_halt_req), 32'h0);
`else
      dbg_resume = 1'b1;
      @(negedge clk);
      dbg_resume = 1'b0;
      chk("resume_ignored", 32'({core_halt_req, dbg_ack, ar_en}), 32'h0);
      @(negedge clk);
      chk("resume_idle", 32'({core_halt_req, dbg_ack, ar_en}), 32'h0);
`endif

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached, expected completion");
      $fatal(1, "watchdog");
   end

endmodule
